// File: rtl/data_mem_lsu.sv
// Load/store unit driving a word-organised data memory: byte/half/word loads
// with lane extraction, word stores, and read-modify-write sub-word stores.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete with resp_err.
module data_mem_lsu #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_en,
    input  logic [31:0] mem_read_data
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic        we_r, uns_r;
    logic [1:0]  size_r, lane_r;
    logic        accept_s, trap_s, err_s;
    logic [31:0] idx_s, rdata_s, wdata_s;
    logic        ready_r, resp_valid_r, resp_err_r, mem_write_en_r;
    logic [31:0] resp_rdata_r, mem_address_r, mem_write_data_r;
    logic        unused_addr_s;

    // Extract the addressed lane of a word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of a word with right-aligned store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: begin
                case (lane)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    2'd3:    r[31:24] = wdata[7:0];
                    default: r = word;
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Half needs an even address, word (size 10 or 11) needs a word-aligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
        return ((size == 2'b01) && low[0]) || (size[1] && (low != 2'b00));
    endfunction

    logic [31:0] wdata_hold_r;

`ifdef MISALIGN_TRAP_EN
    assign trap_s = is_misaligned(req_size, req_addr[1:0]);
`else
    assign trap_s = 1'b0;
`endif

    assign idx_s         = {{(32 - IDX_W){1'b0}}, req_addr[IDX_W+1:2]};
    assign unused_addr_s = &{1'b0, req_addr[31:IDX_W+2]};

    // Next state, and the values each output register takes at the coming edge.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        err_s    = 1'b0;
        rdata_s  = 32'd0;
        wdata_s  = mem_write_data_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (trap_s) begin
                        state_s = ST_RESP;
                        err_s   = 1'b1;
                    end else if (req_we && req_size[1]) begin
                        state_s = ST_WRITE;
                        wdata_s = req_wdata;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (we_r) begin
                    state_s = ST_WRITE;
                    wdata_s = store_merge(mem_read_data, lane_r, size_r, wdata_hold_r);
                end else begin
                    state_s = ST_RESP;
                    rdata_s = load_extend(mem_read_data, lane_r, size_r, uns_r);
                end
            end
            ST_WRITE: state_s = ST_RESP;
            ST_RESP:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r          <= ST_IDLE;
            we_r             <= 1'b0;
            uns_r            <= 1'b0;
            size_r           <= 2'b00;
            lane_r           <= 2'b00;
            wdata_hold_r     <= 32'd0;
            ready_r          <= 1'b1;
            resp_valid_r     <= 1'b0;
            resp_err_r       <= 1'b0;
            resp_rdata_r     <= 32'd0;
            mem_write_en_r   <= 1'b0;
            mem_address_r    <= 32'd0;
            mem_write_data_r <= 32'd0;
        end else begin
            state_r          <= state_s;
            ready_r          <= (state_s == ST_IDLE);
            resp_valid_r     <= (state_s == ST_RESP);
            mem_write_en_r   <= (state_s == ST_WRITE);
            resp_err_r       <= err_s;
            resp_rdata_r     <= rdata_s;
            mem_write_data_r <= wdata_s;
            if (accept_s) begin
                we_r         <= req_we;
                uns_r        <= req_unsigned;
                size_r       <= req_size;
                lane_r       <= req_addr[1:0];
                wdata_hold_r <= req_wdata;
                if (!trap_s) begin
                    mem_address_r <= idx_s;
                end
            end
        end
    end

    assign req_ready      = ready_r;
    assign resp_valid     = resp_valid_r;
    assign resp_rdata     = resp_rdata_r;
    assign resp_err       = resp_err_r;
    assign mem_address    = mem_address_r;
    assign mem_write_data = mem_write_data_r;
    assign mem_write_en   = mem_write_en_r;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: directed table, reset-in-flight sequence and random
// traffic checked against an arithmetic reference model of memory contents.
module tb_data_mem_lsu;

    localparam int MEM_DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_write_en;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

    logic [31:0] mem     [MEM_DEPTH];
    logic [31:0] ref_mem [MEM_DEPTH];
    int          wr_cnt = 0;
    int          total = 0;
    int          passed = 0;

    data_mem_lsu #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[9:0]];

    always @(posedge clk) begin
        if (mem_write_en === 1'b1) begin
            mem[mem_address[9:0]] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: memory semantics from plain byte arithmetic.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err, output int lat,
                              output int writes);
        int     idx, off, bytes;
        bit     mis;
        longint word, mask, v;
        idx   = int'((addr >> 2) % MEM_DEPTH);
        bytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off   = int'(addr % 4);
        mis   = (off % bytes) != 0;
        rdata = 32'd0; err = 1'b0; writes = 0;
`ifdef MISALIGN_TRAP_EN
        if (mis) begin
            err = 1'b1; lat = 1;
            return;
        end
`endif
        off  = off - (off % bytes);
        word = longint'(ref_mem[idx]);
        mask = ((64'd1 << (8 * bytes)) - 1) << (8 * off);
        if (we) begin
            word = (word & ~mask) | ((longint'(wdata) << (8 * off)) & mask);
            ref_mem[idx] = word[31:0];
            lat = (bytes == 4) ? 2 : 3;
            writes = 1;
        end else begin
            v = (word & mask) >> (8 * off);
            if (!uns && bytes < 4 && v[8*bytes-1]) v = v | ~((64'd1 << (8 * bytes)) - 1);
            rdata = v[31:0];
            lat = 2;
        end
    endtask

    // One transaction; junk request traffic is driven while the unit is busy.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output logic [31:0] addr_seen, output int writes);
        int w0, n, guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 5) begin
            @(posedge clk); #1; guard++;
        end
        w0 = wr_cnt;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        addr_seen = mem_address;
        n = 1;
        while (resp_valid !== 1'b1 && n < 8) begin
            req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
            req_addr = $urandom; req_wdata = $urandom; req_unsigned = 1'($urandom);
            @(posedge clk); #1; n++;
        end
        req_valid = 1'b0;
        lat   = (resp_valid === 1'b1) ? n : 99;
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clk); #1;
        writes = wr_cnt - w0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] er, logic ee, int el);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    initial begin
        logic [31:0] rd, as, rrd;
        logic        er, rer;
        int          lat, wr, rlat, rwr, bad, w0;
        bit          saw_resp;

        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] = 32'd0; ref_mem[i] = 32'd0;
        end
        mem[1] = 32'h1122_3344; ref_mem[1] = 32'h1122_3344;

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_outs", {resp_valid, resp_err, mem_write_en, resp_rdata | mem_address | mem_write_data},
              35'd0);
        check("rst_no_write", wr_cnt, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 32'd0, 1'b0, 2));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'd0, 32'hDEAD_BEEF, 1'b0, 2));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h0000_00AA, 32'd0, 1'b0, 3));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'd0, 32'hFFFF_FFAA, 1'b0, 2));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0005, 32'd0, 32'h0000_00AA, 1'b0, 2));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'd0, 32'h1122_AA44, 1'b0, 2));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'd0, 32'd0, 1'b1, 1));
`else
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'd0, 32'hFFFF_AA44, 1'b0, 2));
`endif
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_8001, 32'd0, 1'b0, 3));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'd0, 32'hFFFF_8001, 1'b0, 2));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0006, 32'd0, 32'h0000_8001, 1'b0, 2));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'd0, 32'h8001_AA44, 1'b0, 2));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'hCAFE_F00D, 32'd0, 1'b0, 2));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'd0, 32'd0, 1'b1, 1));
`else
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'd0, 32'hCAFE_F00D, 1'b0, 2));
`endif
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 32'h0000_000C, 32'h1234_5678, 32'd0, 1'b0, 2));
        vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0000_000C, 32'd0, 32'h1234_5678, 1'b0, 2));

        foreach (vecs[i]) begin
            ref_access(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                       rrd, rer, rlat, rwr);
            run_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    rd, er, lat, as, wr);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_writes", i), wr, (vecs[i].we && !vecs[i].exp_err) ? 1 : 0);
            if (!vecs[i].exp_err)
                check($sformatf("vec%0d_mem_address", i), as, (vecs[i].addr >> 2) % MEM_DEPTH);
        end
        check("word1_after_table", mem[1], 32'h8001_AA44);

        // Reset during the READ cycle of a byte store: nothing may commit or respond.
        w0 = wr_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0000_0005; req_wdata = 32'h0000_0055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        saw_resp = (resp_valid === 1'b1);
        check("midrst_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) saw_resp = 1'b1;
        end
        check("midrst_no_resp", 32'(saw_resp), 32'd0);
        check("midrst_no_write", wr_cnt - w0, 32'd0);
        check("midrst_mem_kept", mem[1], 32'h8001_AA44);

        for (int t = 0; t < 200; t++) begin
            logic        we, uns;
            logic [1:0]  size;
            logic [31:0] addr, wdata;
            we = 1'($urandom); uns = 1'($urandom); size = 2'($urandom);
            addr = $urandom & 32'hFFFF_F03F;
            wdata = $urandom;
            ref_access(we, size, uns, addr, wdata, rrd, rer, rlat, rwr);
            run_txn(we, size, uns, addr, wdata, rd, er, lat, as, wr);
            check($sformatf("rnd%0d_rdata", t), rd, rrd);
            check($sformatf("rnd%0d_err", t), 32'(er), 32'(rer));
            check($sformatf("rnd%0d_latency", t), lat, rlat);
            check($sformatf("rnd%0d_writes", t), wr, rwr);
        end

        bad = 0;
        for (int i = 0; i < MEM_DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("final_mem_image", bad, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
